// File: rtl/mem_arb_pkg.sv
// Shared types and byte-lane helpers for the IF/MEM memory port arbiter.
// Holds the FSM state and owner enums, the full-word byte-enable constant,
// and the little-endian byte-enable / byte-extract helpers.
package mem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

  localparam logic [3:0] BE_WORD = 4'hF;

  function automatic logic [3:0] byte_be(input logic [1:0] addr_lo);
    return 4'b0001 << addr_lo;
  endfunction

  function automatic logic [31:0] byte_extract(input logic [31:0] word,
                                               input logic [1:0]  addr_lo);
    logic [7:0] b;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {24'b0, b};
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering for 32-bit little-endian accesses.
// Ports:
//   byte_en  in   1   byte access when 1, word access when 0
//   addr_lo  in   2   byte offset within the word
//   st_data  in   32  store data from the pipeline (byte store uses [7:0])
//   ld_word  in   32  word read from memory
//   be       out  4   byte enables
//   st_word  out  32  store data replicated onto all lanes for byte stores
//   ld_data  out  32  load data, selected lane zero-extended for byte loads
module mem_byte_lane
  import mem_arb_pkg::*;
(
  input  logic        byte_en,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  always_comb begin
    be      = BE_WORD;
    st_word = st_data;
    ld_data = ld_word;
    if (byte_en) begin
      be      = byte_be(addr_lo);
      st_word = {4{st_data[7:0]}};
      ld_data = byte_extract(ld_word, addr_lo);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port fixed-latency memory between the IF-stage fetch
// port and the MEM-stage data port. Each access runs IDLE -> ACCESS (MEM_LAT
// cycles, memory strobes registered and held) -> RESP (one-cycle valid pulse).
// Data has priority over fetch unless fetch has waited through STARVE_MAX
// consecutive data grants.
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   if_req/if_addr             fetch request (level-held) and word address
//   if_rdata/if_valid          fetched word and one-cycle completion pulse
//   d_re/d_we/d_byte           data read, write, byte-size flags (level-held)
//   d_addr/d_wdata             data address and store data
//   d_rdata/d_valid            load data and one-cycle completion pulse
//   stall_if/stall_mem         per-stage stall while an access is pending
//   mem_addr/re/we/be/wdata    registered memory strobes (word aligned address)
//   mem_rdata                  memory read data
// Optional build macro ARB_PERF_CNT_EN adds perf_conflict_cnt and
// perf_stall_cnt output ports (wrapping 32-bit event counters).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_re,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_conflict_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int SW    = $clog2(STARVE_MAX + 1);

  arb_state_t        state, state_nxt;
  arb_owner_t        owner, owner_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_nxt;
  logic [SW-1:0]     starve_cnt, starve_nxt;
  logic              grant, d_req, starved, last_beat;
  logic              acc_byte, acc_re;
  logic [1:0]        acc_lo;
  logic              lane_byte;
  logic [1:0]        lane_lo;
  logic [3:0]        lane_be;
  logic [31:0]       lane_st, lane_ld;
  logic [ADDR_W-1:0] grant_addr;

  assign d_req     = d_re | d_we;
  assign starved   = if_req && (starve_cnt == SW'(STARVE_MAX));
  assign last_beat = (state == ARB_ACCESS) && (lat_cnt == LAT_W'(MEM_LAT));
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

  // The lane unit serves the store path at grant time and the load path on
  // the last access beat, so it sees the live request in IDLE and the latched
  // request afterwards.
  assign lane_byte  = (state == ARB_IDLE) ? d_byte : acc_byte;
  assign lane_lo    = (state == ARB_IDLE) ? d_addr[1:0] : acc_lo;
  assign grant_addr = (owner_nxt == OWN_D) ? d_addr : if_addr;

  mem_byte_lane u_lane (
    .byte_en (lane_byte),
    .addr_lo (lane_lo),
    .st_data (d_wdata),
    .ld_word (mem_rdata),
    .be      (lane_be),
    .st_word (lane_st),
    .ld_data (lane_ld)
  );

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    lat_nxt    = lat_cnt;
    starve_nxt = starve_cnt;
    grant      = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (!if_req) starve_nxt = '0;
        // starved already implies if_req, so the increment never passes STARVE_MAX
        if (d_req && !starved) begin
          grant     = 1'b1;
          owner_nxt = OWN_D;
          if (if_req) starve_nxt = starve_cnt + 1'b1;
        end else if (if_req) begin
          grant      = 1'b1;
          owner_nxt  = OWN_IF;
          starve_nxt = '0;
        end
        if (grant) begin
          state_nxt = ARB_ACCESS;
          lat_nxt   = LAT_W'(1);
        end
      end
      ARB_ACCESS: begin
        if (last_beat) state_nxt = ARB_RESP;
        else           lat_nxt   = lat_cnt + 1'b1;
      end
      ARB_RESP:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IF;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      lat_cnt    <= lat_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      acc_byte  <= 1'b0;
      acc_re    <= 1'b0;
      acc_lo    <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (grant) begin
        mem_addr <= grant_addr & ~ADDR_W'(3);
        if (owner_nxt == OWN_D) begin
          mem_re    <= d_re;
          mem_we    <= d_we;
          mem_be    <= lane_be;
          mem_wdata <= d_we ? lane_st : '0;
          acc_byte  <= d_byte;
          acc_re    <= d_re;
          acc_lo    <= d_addr[1:0];
        end else begin
          mem_re    <= 1'b1;
          mem_we    <= 1'b0;
          mem_be    <= BE_WORD;
          mem_wdata <= '0;
          acc_byte  <= 1'b0;
          acc_re    <= 1'b0;
        end
      end
      if (last_beat) begin
        mem_addr  <= '0;
        mem_re    <= 1'b0;
        mem_we    <= 1'b0;
        mem_be    <= '0;
        mem_wdata <= '0;
        if (owner == OWN_IF) begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          d_valid <= 1'b1;
          if (acc_re) d_rdata <= lane_ld;
        end
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_conflict_cnt <= '0;
      perf_stall_cnt    <= '0;
    end else begin
      if (state == ARB_IDLE && if_req && d_req) perf_conflict_cnt <= perf_conflict_cnt + 1'b1;
      if (stall_if | stall_mem)                 perf_stall_cnt    <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule
